// File: rtl/ram_stream_reader_if.sv
// rtl/ram_stream_reader_if.sv - valid/ready output stream of the RAM reader.
// The master drives data, valid and last; the slave drives ready.
interface ram_stream_reader_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  m_valid_o;
  logic                  m_ready_i;
  logic [DATA_WIDTH-1:0] m_data_o;
  logic                  m_last_o;

  modport master (
    output m_valid_o,
    output m_data_o,
    output m_last_o,
    input  m_ready_i
  );

  modport slave (
    input  m_valid_o,
    input  m_data_o,
    input  m_last_o,
    output m_ready_i
  );
endinterface

// File: rtl/ram_stream_reader.sv
// rtl/ram_stream_reader.sv - streams len words from a combinational-read RAM.
// One-deep registered output stage; wraps addresses silently at the RAM depth.
module ram_stream_reader #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  start_i,
  input  logic [ADDR_WIDTH-1:0] base_addr_i,
  input  logic [ADDR_WIDTH:0]   len_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [ADDR_WIDTH-1:0] rd_addr_o,
  input  logic [DATA_WIDTH-1:0] rd_data_i,
  ram_stream_reader_if.master   m_if
);

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_e;

  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = 1;
  localparam logic [ADDR_WIDTH:0]   LEN_ONE  = 1;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH:0]   remaining_q, remaining_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  valid_q, valid_d;
  logic                  last_q, last_d;
  logic                  done_q, done_d;
  logic                  load;
  logic                  handshake;

  // The output register refills whenever it is empty or being drained this cycle.
  assign handshake = valid_q & m_if.m_ready_i;
  assign load      = (state_q == STREAM) && (remaining_q != '0) &&
                     (!valid_q || m_if.m_ready_i);

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    remaining_d = remaining_q;
    data_d      = data_q;
    valid_d     = valid_q;
    last_d      = last_q;
    done_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          if (len_i != '0) begin
            addr_d      = base_addr_i;
            remaining_d = len_i;
            state_d     = STREAM;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      STREAM: begin
        if (load) begin
          data_d      = rd_data_i;
          valid_d     = 1'b1;
          last_d      = (remaining_q == LEN_ONE);
          addr_d      = addr_q + ADDR_ONE;
          remaining_d = remaining_q - LEN_ONE;
        end else if (handshake) begin
          valid_d = 1'b0;
          if (last_q) begin
            last_d  = 1'b0;
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      remaining_q <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      last_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      remaining_q <= remaining_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      last_q      <= last_d;
      done_q      <= done_d;
    end
  end

  assign busy_o       = (state_q == STREAM);
  assign done_o       = done_q;
  assign rd_addr_o    = addr_q;
  assign m_if.m_valid_o = valid_q;
  assign m_if.m_data_o  = data_q;
  assign m_if.m_last_o  = last_q;

endmodule

// File: tb/tb_ram_stream_reader.sv
// tb/tb_ram_stream_reader.sv - directed bench with a queue-based beat model.
// Expected beats are computed from the RAM contents and command base/len.
module tb_ram_stream_reader;

  localparam int DW = 32;
  localparam int AW = 3;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [AW:0]   len;
  logic          busy;
  logic          done;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic [DW-1:0] mem [DEPTH];

  ram_stream_reader_if #(.DATA_WIDTH(DW)) s_if ();

  ram_stream_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .start_i     (start),
    .base_addr_i (base_addr),
    .len_i       (len),
    .busy_o      (busy),
    .done_o      (done),
    .rd_addr_o   (rd_addr),
    .rd_data_i   (rd_data),
    .m_if        (s_if.master)
  );

  always #5 clk = ~clk;
  assign rd_data = mem[rd_addr];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int done_cycle = -1;
  int start_cyc;
  int done_seen_cyc;
  logic [DW-1:0] exp_data [$];
  logic          exp_last [$];
  logic [DW-1:0] got_data [$];
  int            got_cyc  [$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Per-cycle compare against the beat queue and the expected done cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("done_pulse", done, (cyc == done_cycle));
      if (s_if.m_valid_o) begin
        if (exp_data.size() == 0) begin
          chk("spurious_valid", s_if.m_valid_o, 1'b0);
        end else begin
          chk("beat_data", s_if.m_data_o, exp_data[0]);
          chk("beat_last", s_if.m_last_o, exp_last[0]);
          if (s_if.m_ready_i) begin
            got_data.push_back(s_if.m_data_o);
            got_cyc.push_back(cyc);
            if (exp_last[0]) done_cycle = cyc + 1;
            void'(exp_data.pop_front());
            void'(exp_last.pop_front());
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_cmd(input int b, input int l);
    start     = 1'b1;
    base_addr = AW'(b);
    len       = (AW+1)'(l);
    start_cyc = cyc;
    for (int i = 0; i < l; i++) begin
      exp_data.push_back(mem[(b + i) % DEPTH]);
      exp_last.push_back(i == l - 1);
    end
    if (l == 0) done_cycle = cyc + 1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int k;
    for (k = 0; k < 40; k++) begin
      if (done) break;
      tick();
    end
    done_seen_cyc = cyc;
    if (k == 40) chk({name, "_timeout"}, 1'b0, 1'b1);
  endtask

  task automatic check_zero(input string name);
    chk({name, "_valid"}, s_if.m_valid_o, 1'b0);
    chk({name, "_last"},  s_if.m_last_o, 1'b0);
    chk({name, "_data"},  s_if.m_data_o, '0);
    chk({name, "_busy"},  busy, 1'b0);
    chk({name, "_done"},  done, 1'b0);
    chk({name, "_addr"},  rd_addr, '0);
  endtask

  int pat [6] = '{1, 0, 0, 1, 0, 1};

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = 32'h100 + i;
    rst_n = 1'b0; start = 1'b0; base_addr = '0; len = '0; s_if.m_ready_i = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    rst_n = 1'b1;
    tick();

    // Basic stream, ready held high.
    got_data.delete(); got_cyc.delete();
    start_cmd(2, 4);
    chk("model_first", exp_data[0], 32'h102);
    wait_done("basic");
    chk("basic_count", got_data.size(), 4);
    if (got_data.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        chk("basic_beat", got_data[i], 32'h102 + i);
        chk("basic_cycle", got_cyc[i], start_cyc + 2 + i);
      end
    end
    chk("basic_done_cycle", done_seen_cyc, start_cyc + 6);
    tick();

    // Wrap-around.
    got_data.delete(); got_cyc.delete();
    start_cmd(6, 4);
    wait_done("wrap");
    chk("wrap_count", got_data.size(), 4);
    if (got_data.size() == 4) begin
      chk("wrap_b0", got_data[0], 32'h106);
      chk("wrap_b1", got_data[1], 32'h107);
      chk("wrap_b2", got_data[2], 32'h100);
      chk("wrap_b3", got_data[3], 32'h101);
    end
    tick();

    // Backpressure pattern applied from the first valid cycle.
    got_data.delete(); got_cyc.delete();
    start_cmd(1, 3);
    tick();
    for (int k = 0; k < 6; k++) begin
      s_if.m_ready_i = pat[k][0];
      tick();
    end
    s_if.m_ready_i = 1'b1;
    wait_done("stall");
    chk("stall_count", got_data.size(), 3);
    if (got_data.size() == 3) begin
      chk("stall_b0", got_data[0], 32'h101);
      chk("stall_b2", got_data[2], 32'h103);
      chk("stall_c0", got_cyc[0], start_cyc + 2);
      chk("stall_c1", got_cyc[1], start_cyc + 5);
      chk("stall_c2", got_cyc[2], start_cyc + 7);
    end
    tick();

    // Zero-length command.
    start_cmd(4, 0);
    chk("len0_busy", busy, 1'b0);
    chk("len0_done", done, 1'b1);
    tick();
    chk("len0_done_clear", done, 1'b0);
    chk("len0_busy2", busy, 1'b0);

    // Start while busy is ignored; back-to-back start in the done cycle.
    got_data.delete(); got_cyc.delete();
    start_cmd(0, 3);
    chk("busy_high", busy, 1'b1);
    start = 1'b1; base_addr = 3'd5; len = 4'd2;
    tick();
    start = 1'b0;
    wait_done("ignored");
    start_cmd(0, 2);
    wait_done("b2b");
    chk("b2b_count", got_data.size(), 5);
    if (got_data.size() == 5) begin
      chk("b2b_b3", got_data[3], 32'h100);
      chk("b2b_b4", got_data[4], 32'h101);
    end
    tick();

    // Full depth from a non-zero base.
    got_data.delete(); got_cyc.delete();
    start_cmd(5, 8);
    wait_done("full");
    chk("full_count", got_data.size(), 8);
    if (got_data.size() == 8) chk("full_b3", got_data[3], 32'h100);
    tick();

    // Reset after the second of five beats.
    got_data.delete(); got_cyc.delete();
    start_cmd(1, 5);
    for (int k = 0; k < 20; k++) begin
      tick();
      if (got_data.size() >= 2) break;
    end
    #2 rst_n = 1'b0;
    #1;
    check_zero("midreset");
    exp_data.delete(); exp_last.delete();
    done_cycle = -1;
    tick(); tick();
    rst_n = 1'b1;
    tick();
    chk("midreset_beats", got_data.size(), 2);
    got_data.delete(); got_cyc.delete();
    start_cmd(3, 1);
    wait_done("after_reset");
    chk("after_reset_count", got_data.size(), 1);
    if (got_data.size() == 1) chk("after_reset_b0", got_data[0], 32'h103);
    tick(); tick();
    chk("end_queue_empty", exp_data.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
